// File: rtl/pll_clkgen_if.sv
// Configuration write bus for pll_clkgen: master drives the write, slave returns cfg_ready.
interface pll_clkgen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_ready;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/pll_clkgen.sv
// Multi-channel programmable clock divider with phase delay, wrap-aligned ratio updates and lock status.
// Optional macro PLL_DUTY50_EN adds a falling-edge stage giving 50% duty for odd ratios.
module pll_clkgen #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 2,
    parameter int unsigned LOCK_CNT    = 4
) (
    input  logic              ref_clk,
    input  logic              rst,
    pll_clkgen_if.slave       cfg,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] out_stb,
    output logic [NUM_CH-1:0] locked
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CH_SPAN = 1 << CH_W;
    localparam int unsigned LK_W    = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [LK_W-1:0]  LK_TGT  = LK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_RUN,
        ST_STOP
    } state_t;

    logic [NUM_CH-1:0]  pend_vec;
    logic [CH_SPAN-1:0] pend_ext;
    logic [DIV_W-1:0]   wr_div;
    logic               wr_ok;

    // Unimplemented channel numbers read as never-pending, so they stay ready and match no channel.
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pend_vec;
    end

    assign cfg.cfg_ready = ~pend_ext[cfg.cfg_ch];
    assign wr_ok         = cfg.cfg_we & cfg.cfg_ready;
    assign wr_div        = (cfg.cfg_div < DIV_MIN) ? DIV_MIN : cfg.cfg_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           st, st_n;
        logic [DIV_W-1:0] cnt, cnt_n;
        logic [DIV_W-1:0] div, div_n;
        logic [DIV_W-1:0] sdiv, sdiv_n;
        logic [DIV_W-1:0] ph, ph_n;
        logic             pend, pend_n;
        logic [LK_W-1:0]  pc, pc_n, pc_inc;
        logic             lk, lk_n;
        logic             clk_q, clk_n;
        logic             stb_q, stb_n;
        logic             wr;
        logic             wrap;

        assign wr     = wr_ok && (cfg.cfg_ch == CH_W'(i));
        assign wrap   = (cnt >= div - DIV_W'(1));
        assign pc_inc = pc + LK_W'(1);

        // Next-state: the counter wrap is the only point a running channel changes ratio or stops.
        always_comb begin
            st_n   = st;
            cnt_n  = cnt;
            div_n  = div;
            sdiv_n = sdiv;
            ph_n   = ph;
            pend_n = pend;
            pc_n   = pc;
            lk_n   = lk;

            if (wr) begin
                sdiv_n = wr_div;
                ph_n   = cfg.cfg_phase;
                pend_n = 1'b1;
            end

            case (st)
                ST_IDLE: begin
                    cnt_n = '0;
                    pc_n  = '0;
                    lk_n  = 1'b0;
                    if (pend) begin
                        div_n  = sdiv;
                        pend_n = 1'b0;
                    end
                    if (ch_en[i]) begin
                        if (ph == '0) begin
                            st_n = ST_RUN;
                        end else begin
                            st_n  = ST_DELAY;
                            cnt_n = ph;
                        end
                    end
                end

                ST_DELAY: begin
                    if (!ch_en[i]) begin
                        st_n  = ST_IDLE;
                        cnt_n = '0;
                    end else if (cnt <= DIV_W'(1)) begin
                        st_n  = ST_RUN;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt - DIV_W'(1);
                    end
                end

                ST_RUN: begin
                    if (wrap) begin
                        cnt_n = '0;
                        if (pend) begin
                            div_n  = sdiv;
                            pend_n = 1'b0;
                            pc_n   = '0;
                            lk_n   = 1'b0;
                        end else if (!lk) begin
                            pc_n = pc_inc;
                            lk_n = (pc_inc >= LK_TGT);
                        end
                        if (!ch_en[i]) begin
                            st_n = ST_STOP;
                            pc_n = '0;
                            lk_n = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt + DIV_W'(1);
                    end
                end

                ST_STOP: begin
                    st_n  = ST_IDLE;
                    cnt_n = '0;
                    pc_n  = '0;
                    lk_n  = 1'b0;
                end

                default: begin
                    st_n  = ST_IDLE;
                    cnt_n = '0;
                end
            endcase

            // Outputs are computed from the next state so the registers line up with cnt.
            clk_n = (st_n == ST_RUN) && (cnt_n < (div_n >> 1));
            stb_n = (st_n == ST_RUN) && (cnt_n == '0);
        end

        always_ff @(posedge ref_clk) begin
            if (rst) begin
                st    <= ST_IDLE;
                cnt   <= '0;
                div   <= DIV_RST;
                sdiv  <= DIV_RST;
                ph    <= '0;
                pend  <= 1'b0;
                pc    <= '0;
                lk    <= 1'b0;
                clk_q <= 1'b0;
                stb_q <= 1'b0;
            end else begin
                st    <= st_n;
                cnt   <= cnt_n;
                div   <= div_n;
                sdiv  <= sdiv_n;
                ph    <= ph_n;
                pend  <= pend_n;
                pc    <= pc_n;
                lk    <= lk_n;
                clk_q <= clk_n;
                stb_q <= stb_n;
            end
        end

        assign pend_vec[i] = pend;
        assign out_stb[i]  = stb_q;
        assign locked[i]   = lk;

`ifdef PLL_DUTY50_EN
        logic odd_q;
        logic neg_q;

        // Odd-ratio flag gates the half-cycle extension; clearing it on reset forces out_clk low at once.
        always_ff @(posedge ref_clk) begin
            if (rst) begin
                odd_q <= 1'b0;
            end else begin
                odd_q <= (st_n == ST_RUN) && div_n[0];
            end
        end

        always_ff @(negedge ref_clk) begin
            if (rst) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= clk_q;
            end
        end

        assign out_clk[i] = clk_q | (neg_q & odd_q);
`else
        assign out_clk[i] = clk_q;
`endif
    end

endmodule

// File: doc/pll_clkgen.md
Name: pll_clkgen

Overview:
- Multi-channel programmable clock generator that derives NUM_CH divided output clocks from ref_clk.
- Next generation of the fixed pll block: per-channel divide ratio, phase offset, glitch-free ratio updates, clean enable/disable, and per-channel lock status.
- Sits between the reference clock source and downstream logic that needs slower clocks or clock strobes.
- All logic runs on ref_clk; outputs are registered.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- DIV_W, 8, width of divide ratio and phase fields.
- DIV_DEFAULT, 2, divide ratio loaded at reset (must be >= 2).
- LOCK_CNT, 4, complete output periods at a stable ratio before locked asserts.

Ports:
- ref_clk  input  1  reference clock; all state is updated on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_div  input  DIV_W  new divide ratio N.
- cfg_phase  input  DIV_W  start delay in ref_clk cycles.
- cfg_ready  output  1  high when a write to cfg_ch is accepted.
- ch_en  input  NUM_CH  per-channel run enable.
- out_clk  output  NUM_CH  divided clocks.
- out_stb  output  NUM_CH  one-cycle pulse coincident with each out_clk rising edge.
- locked  output  NUM_CH  per-channel stable-ratio indicator.

Behaviour:
- Reset (synchronous, active-high, one clock only):
  - out_clk = 0, out_stb = 0, locked = 0.
  - Counters = 0, all channels IDLE.
  - Active and shadow ratio = DIV_DEFAULT; phase = 0; pending = 0.
  - cfg_ready = 1.
  - Reset asserted mid-operation aborts every state on the next edge; no output glitch beyond forcing low.
- Per-channel states: IDLE, DELAY, RUN, STOP.
- IDLE:
  - out_clk = 0; counter held at 0.
  - ch_en = 1 -> DELAY with delay counter = phase.
  - If phase = 0, go directly to RUN.
- DELAY:
  - out_clk = 0; decrement each cycle.
  - Enter RUN on the cycle after the count reaches 0, with cnt = 0.
  - ch_en dropping in DELAY -> IDLE immediately.
- RUN:
  - cnt counts 0..N-1 and wraps.
  - out_clk = 1 while cnt < floor(N/2), else 0.
  - out_stb = 1 in the cycle with cnt = 0.
  - Resulting high time is floor(N/2) cycles and period is N cycles (e.g. N=5: 2 high, 3 low).
- Wrap point (cnt = N-1) is the only point where changes take effect:
  - A pending shadow ratio is copied to active and pending clears.
  - If ch_en = 0, the channel goes to STOP.
- STOP: out_clk = 0, cnt = 0, locked = 0; next cycle -> IDLE.
  - This guarantees no runt pulse: a period always completes.
- Configuration:
  - Write accepted when cfg_we = 1 and cfg_ready = 1.
  - cfg_ready = ~pending[cfg_ch] (combinational on cfg_ch).
  - An accepted write loads the shadow ratio and phase and sets pending.
  - For an IDLE channel, the shadow is applied on the next cycle.
  - cfg_div < 2 is clamped to 2.
  - A write while pending is ignored.
  - cfg_ch >= NUM_CH: write ignored, cfg_ready = 1.
- Phase applies only on the next IDLE->DELAY entry.
- Lock:
  - A per-channel period counter increments at each wrap.
  - locked = 1 once LOCK_CNT wraps occur at an unchanged ratio.
  - Clears in the cycle a new ratio is applied at a wrap, and in STOP/IDLE.
- Simultaneous wrap, ch_en = 0 and a pending ratio: the ratio is applied and the channel stops.

Optional Feature:
- PLL_DUTY50_EN defined:
  - Each channel adds one ref_clk falling-edge register.
  - For odd N, out_clk stays high an extra half ref_clk cycle, giving exactly 50% duty.
  - Even N is unchanged.
  - out_stb timing is unchanged.
- Not defined:
  - Single-edge logic only.
  - Duty = floor(N/2)/N.

Test Plan:
- Reset check: reset, ch_en = 0001, default N = 2 -> out_clk[0] toggles every cycle; out_stb[0] pulses every 2 cycles; locked[0] high after 4 periods (8 cycles after RUN entry).
- Ratio update: write ch1 N = 5 phase = 3, ch_en[1] = 1 -> out_clk[1] stays low 3 cycles, then a 2-high/3-low pattern.
- Glitch-free change: write N = 8 mid-period -> current 5-cycle period completes unchanged, then 4-high/4-low; locked[1] drops at the switch and re-asserts after 4 periods. A second write before the switch sees cfg_ready = 0 and is ignored.
- Clamp: write N = 0 and N = 1 -> behave as N = 2.
- Disable: drop ch_en[2] at cnt = 1 of N = 6 -> period finishes (3 high, 3 low), then out_clk = 0 and locked = 0. Re-enable with phase = 0 -> RUN restarts at cnt = 0 with out_stb.
- Reset mid-run with all channels active -> all outputs 0 next cycle; ratios restored to DIV_DEFAULT.
- With PLL_DUTY50_EN, N = 5 -> high time 2.5 ref_clk periods.
